store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer between the MEM-stage load/store path and the word-addressed data memory. It accepts stores from the pipeline into a small FIFO and retires them to memory one per cycle whenever the memory port is not needed by a load. Loads take priority over draining and are served from the youngest matching buffered store when one exists, otherwise from memory. Only full-word accesses are handled; addresses are word indices, passed through unchanged.

## Interface
- DEPTH, 4, number of buffered stores; power of two, at least 2
- AW, 32, address width
- DW, 32, data width
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low (buffer cleared while 0)
- st_valid  input  1  store request from pipeline
- st_addr  input  AW  store word address
- st_data  input  DW  store data
- st_ready  output  1  buffer can accept a store; equals not-full
- ld_valid  input  1  load request from pipeline
- ld_addr  input  AW  load word address
- ld_data  output  DW  load result, same cycle
- drain_req  input  1  pipeline requests the buffer be emptied (fence/sync)
- empty  output  1  no stores pending
- mem_write  output  1  to data memory write enable
- mem_read  output  1  to data memory read enable
- mem_address  output  AW  to data memory address
- mem_write_data  output  DW  to data memory write data
- mem_data_read  input  DW  from data memory, combinational read

## Operation
- Storage: circular FIFO of DEPTH entries {addr, data}; head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH; count of log2(DEPTH)+1 bits.
- Push: st_valid && st_ready at a clock edge writes the entry at tail; tail increments and wraps.
- Port arbitration each cycle:
  - ld_valid=1: mem_read=1, mem_write=0, mem_address=ld_addr; no drain this cycle.
  - ld_valid=0, count>0: mem_write=1, mem_read=0, mem_address/mem_write_data = head entry; head increments at the edge.
  - otherwise: mem_write=0, mem_read=0, mem_address=0, mem_write_data=0.
- Load forwarding: compare ld_addr against all valid entries; on any match, ld_data = data of the youngest match (closest to tail); else ld_data = mem_data_read. ld_data=0 when ld_valid=0.
- Same-cycle push is not visible to a same-cycle load; it is visible from the next cycle.
- No coalescing: repeated stores to one address occupy separate entries and retire in order.
- drain_req: has no effect on arbitration (draining is already greedy); the pipeline holds off new stores and waits for empty=1. A store presented while drain_req=1 is still accepted if st_ready=1.
- Simultaneous push and pop: count unchanged; both pointers advance. Push when full is ignored (st_ready=0); the pipeline stalls.

## Timing
- Reset (reset=0): head=tail=count=0 immediately; st_ready=1, empty=1, mem_write=0; pending stores are discarded, including one being driven to memory.
- st_ready and empty are decoded from registered count only; no combinational path from st_valid or ld_valid.
- Store accepted at edge N is first eligible to drive mem_write during cycle N+1; memory is updated at edge N+1 if no load occupies that cycle.
- Load latency 0: ld_data is combinational from ld_addr, buffer contents, mem_data_read.
- Full buffer with a continuous load stream: no drain occurs; st_ready stays 0 until a load-free cycle retires the head.

## Structure
- Shared package: DEPTH-derived pointer width constant, entry struct {addr, data}.
- Sub-module store_buffer_match: takes entries, valid mask, head pointer and ld_addr; returns hit and youngest-match data by priority search from tail-1 back to head.

## Test plan
- Reset then store addr 5 data 0xDEADBEEF with ld_valid=0 -> next cycle mem_write=1, mem_address=5, mem_write_data=0xDEADBEEF; empty=1 afterwards.
- Stores to addr 3 with 0x11 then 0x22 while ld_valid held 1 on addr 3 -> ld_data=0x11 the cycle after the first push, 0x22 after the second; no mem_write while the load is held.
- Four stores with ld_valid held 1 -> st_ready=0 after the 4th; a fifth is not accepted; dropping ld_valid retires addresses in push order, one per cycle.
- Full buffer, simultaneous push and pop in a load-free cycle -> not possible (st_ready=0); at count=3, push+pop leaves count=3 and pointers wrap correctly past DEPTH-1.
- Load addr 9 with no match, mem_data_read=0xCAFE0000 -> ld_data=0xCAFE0000, mem_read=1.
- Three stores pending, reset pulsed low mid-drain -> empty=1, mem_write=0 immediately; no further writes reach memory.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared sizing constants and entry type for the store buffer
package store_buffer_pkg;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// rtl/store_buffer_match.sv - youngest-match search of buffered stores for load forwarding
module store_buffer_match
   import store_buffer_pkg::*;
(
   input  sb_entry_t        entries_i [DEPTH],
   input  logic [DEPTH-1:0] valid_i,
   input  logic [PTR_W-1:0] head_i,
   input  logic [AW-1:0]    ld_addr_i,
   output logic             hit_o,
   output logic [DW-1:0]    data_o
);

   logic [PTR_W-1:0] idx;

   // Walk oldest to youngest; later matches overwrite earlier ones, so the
   // entry closest to tail wins.
   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      idx    = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_i + PTR_W'(k);
         if (valid_i[idx] && entries_i[idx].addr == ld_addr_i) begin
            hit_o  = 1'b1;
            data_o = entries_i[idx].data;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write FIFO between MEM stage and data memory
// Loads own the memory port; buffered stores retire one per load-free cycle.
module store_buffer
   import store_buffer_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          st_valid,
   input  logic [AW-1:0] st_addr,
   input  logic [DW-1:0] st_data,
   output logic          st_ready,
   input  logic          ld_valid,
   input  logic [AW-1:0] ld_addr,
   output logic [DW-1:0] ld_data,
   input  logic          drain_req,
   output logic          empty,
   output logic          mem_write,
   output logic          mem_read,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_write_data,
   input  logic [DW-1:0] mem_data_read
);

   sb_entry_t        entries_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push, pop;
   logic [DEPTH-1:0] valid;
   logic             fwd_hit;
   logic [DW-1:0]    fwd_data;
   logic             unused_drain;

   // Draining is already greedy, so a fence only needs to watch empty.
   assign unused_drain = drain_req;

   assign st_ready = (count_q != CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign push     = st_valid && st_ready;
   assign pop      = !ld_valid && !empty;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         valid[i] = ({1'b0, PTR_W'(i) - head_q} < count_q);
      end
   end

   always_comb begin
      head_d  = pop  ? head_q + 1'b1 : head_q;
      tail_d  = push ? tail_q + 1'b1 : tail_q;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         entries_q[tail_q] <= '{addr: st_addr, data: st_data};
      end
   end

   store_buffer_match u_match (
      .entries_i (entries_q),
      .valid_i   (valid),
      .head_i    (head_q),
      .ld_addr_i (ld_addr),
      .hit_o     (fwd_hit),
      .data_o    (fwd_data)
   );

   always_comb begin
      mem_read       = ld_valid;
      mem_write      = pop;
      mem_address    = '0;
      mem_write_data = '0;
      if (ld_valid) begin
         mem_address = ld_addr;
      end else if (pop) begin
         mem_address    = entries_q[head_q].addr;
         mem_write_data = entries_q[head_q].data;
      end
      ld_data = ld_valid ? (fwd_hit ? fwd_data : mem_data_read) : '0;
   end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        st_valid;
   logic [31:0] st_addr, st_data;
   logic        st_ready;
   logic        ld_valid;
   logic [31:0] ld_addr, ld_data;
   logic        drain_req;
   logic        empty;
   logic        mem_write, mem_read;
   logic [31:0] mem_address, mem_write_data, mem_data_read;

   int tests = 0;
   int fails = 0;
   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];

   always #5 clk = ~clk;

   store_buffer dut (
      .clk            (clk),
      .reset          (reset),
      .st_valid       (st_valid),
      .st_addr        (st_addr),
      .st_data        (st_data),
      .st_ready       (st_ready),
      .ld_valid       (ld_valid),
      .ld_addr        (ld_addr),
      .ld_data        (ld_data),
      .drain_req      (drain_req),
      .empty          (empty),
      .mem_write      (mem_write),
      .mem_read       (mem_read),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_data_read  (mem_data_read)
   );

   // Memory-side write log
   always @(posedge clk) begin
      if (mem_write) begin
         wa_q.push_back(mem_address);
         wd_q.push_back(mem_write_data);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      reset = 1'b0; st_valid = 0; st_addr = 0; st_data = 0;
      ld_valid = 0; ld_addr = 0; drain_req = 0; mem_data_read = 0;
      #12;
      chk("rst_st_ready", st_ready, 1);
      chk("rst_empty", empty, 1);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_addr", mem_address, 0);
      chk("rst_ld_data", ld_data, 0);
      reset = 1'b1;
      tick();

      // single store retires the next cycle
      st_valid = 1; st_addr = 5; st_data = 32'hDEADBEEF;
      settle();
      chk("t1_no_write_yet", mem_write, 0);
      tick();
      st_valid = 0;
      settle();
      chk("t1_mem_write", mem_write, 1);
      chk("t1_mem_addr", mem_address, 5);
      chk("t1_mem_wdata", mem_write_data, 32'hDEADBEEF);
      chk("t1_not_empty", empty, 0);
      tick();
      chk("t1_empty", empty, 1);
      chk("t1_idle_write", mem_write, 0);
      chk("t1_log_n", wa_q.size(), 1);
      if (wa_q.size() == 1) begin
         chk("t1_log_addr", wa_q[0], 5);
         chk("t1_log_data", wd_q[0], 32'hDEADBEEF);
      end
      wa_q.delete(); wd_q.delete();

      // forwarding: youngest match, push visible only next cycle
      ld_valid = 1; ld_addr = 3; mem_data_read = 32'h55;
      st_valid = 1; st_addr = 3; st_data = 32'h11;
      settle();
      chk("t2_miss_data", ld_data, 32'h55);
      chk("t2_mem_read", mem_read, 1);
      chk("t2_mem_addr", mem_address, 3);
      tick();
      st_data = 32'h22;
      settle();
      chk("t2_fwd_first", ld_data, 32'h11);
      chk("t2_no_write_a", mem_write, 0);
      tick();
      st_valid = 0;
      settle();
      chk("t2_fwd_young", ld_data, 32'h22);
      chk("t2_no_write_b", mem_write, 0);

      // fill to full under a held load, fifth store refused
      st_valid = 1; st_addr = 7; st_data = 32'h77;
      tick();
      st_addr = 8; st_data = 32'h88;
      settle();
      chk("t3_ready_at3", st_ready, 1);
      tick();
      chk("t3_full", st_ready, 0);
      st_addr = 9; st_data = 32'h99;
      tick();
      chk("t3_still_full", st_ready, 0);
      chk("t3_no_write", mem_write, 0);
      st_valid = 0; ld_valid = 0;
      settle();
      chk("t3_ld_data_idle", ld_data, 0);
      chk("t3_d0_addr", mem_address, 3);
      chk("t3_d0_data", mem_write_data, 32'h11);
      tick();
      chk("t3_d1_data", mem_write_data, 32'h22);
      chk("t3_ready_again", st_ready, 1);
      tick();
      chk("t3_d2_addr", mem_address, 7);
      tick();
      chk("t3_d3_addr", mem_address, 8);
      tick();
      chk("t3_empty", empty, 1);
      chk("t3_log_n", wa_q.size(), 4);
      if (wa_q.size() == 4) begin
         chk("t3_log_0", wa_q[0], 3);
         chk("t3_log_1", wa_q[1], 3);
         chk("t3_log_2", wa_q[2], 7);
         chk("t3_log_3", wa_q[3], 8);
      end
      wa_q.delete(); wd_q.delete();

      // count=3 with push+pop, pointers wrap past DEPTH-1
      ld_valid = 1; ld_addr = 100; st_valid = 1;
      for (int i = 0; i < 3; i++) begin
         st_addr = 20 + i; st_data = 32'hA0 + i;
         tick();
      end
      ld_valid = 0; st_addr = 23; st_data = 32'hA3;
      settle();
      chk("t4_ready_at3", st_ready, 1);
      chk("t4_pop_addr", mem_address, 20);
      tick();
      st_valid = 0;
      settle();
      chk("t4_head_addr", mem_address, 21);
      chk("t4_count3_ready", st_ready, 1);
      ld_valid = 1; ld_addr = 23; mem_data_read = 32'h1234;
      settle();
      chk("t4_fwd_wrapped", ld_data, 32'hA3);
      ld_addr = 20;
      settle();
      chk("t4_retired_miss", ld_data, 32'h1234);
      ld_valid = 0;
      for (int i = 0; i < 3; i++) tick();
      chk("t4_empty", empty, 1);
      chk("t4_log_n", wa_q.size(), 4);
      if (wa_q.size() == 4) begin
         chk("t4_log_3_addr", wa_q[3], 23);
         chk("t4_log_3_data", wd_q[3], 32'hA3);
      end
      wa_q.delete(); wd_q.delete();

      // load miss goes to memory
      ld_valid = 1; ld_addr = 9; mem_data_read = 32'hCAFE0000;
      settle();
      chk("t5_ld_data", ld_data, 32'hCAFE0000);
      chk("t5_mem_read", mem_read, 1);
      chk("t5_mem_addr", mem_address, 9);
      chk("t5_mem_write", mem_write, 0);

      // reset mid-drain discards pending stores
      st_valid = 1;
      for (int i = 0; i < 3; i++) begin
         st_addr = 40 + i; st_data = 32'hB0 + i;
         tick();
      end
      st_valid = 0; ld_valid = 0;
      tick();
      chk("t6_writing", mem_write, 1);
      chk("t6_addr41", mem_address, 41);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_rst_empty", empty, 1);
      chk("t6_rst_write", mem_write, 0);
      chk("t6_rst_ready", st_ready, 1);
      tick();
      reset = 1'b1;
      tick();
      tick();
      chk("t6_post_empty", empty, 1);
      chk("t6_log_n", wa_q.size(), 1);
      if (wa_q.size() == 1) chk("t6_log_0", wa_q[0], 40);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
